// File: rtl/jcc_branch_unit_pkg.sv
//------------------------------------------------------------------------------
// Module : jcc_branch_unit_pkg
// Brief  : Shared flag indices, state encoding and opcodes for the branch unit.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package jcc_branch_unit_pkg;

  localparam int OF_IDX = 11;
  localparam int CF_IDX = 0;
  localparam int ZF_IDX = 6;
  localparam int SF_IDX = 7;
  localparam int PF_IDX = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    EVAL     = 3'd2,
    REDIRECT = 3'd3,
    DONE     = 3'd4
  } jcc_state_t;

  localparam logic [7:0] OPC_LOOPNE = 8'he0;
  localparam logic [7:0] OPC_LOOPE  = 8'he1;
  localparam logic [7:0] OPC_LOOP   = 8'he2;
  localparam logic [7:0] OPC_JCXZ   = 8'he3;

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/jcc_branch_unit_jumptest.sv
//------------------------------------------------------------------------------
// Module : jcc_branch_unit_jumptest
// Brief  : JumpTest condition evaluator for Jcc opcodes (low nibble selects).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jcc_branch_unit_jumptest
  import jcc_branch_unit_pkg::*;
(
  input  logic [3:0]  cond_i,
  input  logic [15:0] flags_i,
  output logic        taken_o
);

  logic w_of, w_cf, w_zf, w_sf, w_pf;
  logic w_unused_flags;

  assign w_of = flags_i[OF_IDX];
  assign w_cf = flags_i[CF_IDX];
  assign w_zf = flags_i[ZF_IDX];
  assign w_sf = flags_i[SF_IDX];
  assign w_pf = flags_i[PF_IDX];
  assign w_unused_flags = ^{flags_i[15:12], flags_i[10:8], flags_i[5:3], flags_i[1]};

  // Even conditions are evaluated directly; odd ones are their negation.
  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i[3:1])
      3'd0: taken_o = w_of;
      3'd1: taken_o = w_cf;
      3'd2: taken_o = w_zf;
      3'd3: taken_o = w_cf | w_zf;
      3'd4: taken_o = w_sf;
      3'd5: taken_o = w_pf;
      3'd6: taken_o = w_sf ^ w_of;
      3'd7: taken_o = w_zf | (w_sf ^ w_of);
      default: taken_o = 1'b0;
    endcase
    if (cond_i[0]) taken_o = ~taken_o;
  end

endmodule

`default_nettype wire

// File: rtl/jcc_branch_unit.sv
//------------------------------------------------------------------------------
// Module : jcc_branch_unit
// Brief  : Short conditional branch executor (Jcc, LOOPx, JCXZ).
//          Macro JCC_LOOP_EN enables LOOP/LOOPE/LOOPNE/JCXZ support.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jcc_branch_unit
  import jcc_branch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [15:0] ip,
  input  logic [15:0] flags,
  input  logic [15:0] cx,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_rd_data,
  output logic        fifo_rd_en,
  output logic        cx_wr_en,
  output logic [15:0] cx_wr_data,
  output logic        branch_valid,
  output logic [15:0] branch_ip,
  input  logic        branch_ack,
  output logic        busy,
  output logic        done
);

  jcc_state_t  state_q;
  logic [7:0]  opcode_q;
  logic [7:0]  disp_q;
  logic [15:0] ip_q;
  logic [15:0] flags_q;

  logic        w_jcc_taken;
  logic        w_taken;
  logic        w_supported;
  logic [15:0] w_target;

  jcc_branch_unit_jumptest u_jumptest (
    .cond_i  (opcode_q[3:0]),
    .flags_i (flags_q),
    .taken_o (w_jcc_taken)
  );

  assign w_target = ip_q + sext8(disp_q);

`ifdef JCC_LOOP_EN
  logic [15:0] cx_q;
  logic [15:0] w_cx_dec;
  logic        w_loop_taken;
  logic        w_is_loop;

  assign w_cx_dec = cx_q - 16'd1;

  always_comb begin
    w_loop_taken = 1'b0;
    w_is_loop    = 1'b0;
    unique case (opcode_q)
      OPC_LOOP:   begin w_is_loop = 1'b1; w_loop_taken = (w_cx_dec != 16'd0); end
      OPC_LOOPE:  begin w_is_loop = 1'b1; w_loop_taken = (w_cx_dec != 16'd0) &  flags_q[ZF_IDX]; end
      OPC_LOOPNE: begin w_is_loop = 1'b1; w_loop_taken = (w_cx_dec != 16'd0) & ~flags_q[ZF_IDX]; end
      OPC_JCXZ:   w_loop_taken = (cx_q == 16'd0);
      default:    ;
    endcase
  end

  assign w_supported = (opcode[7:5] == 3'b011) || (opcode[7:2] == OPC_LOOPNE[7:2]);
  assign w_taken     = (opcode_q[7:5] == 3'b011) ? w_jcc_taken : w_loop_taken;
  assign cx_wr_en    = (state_q == EVAL) && w_is_loop;
  assign cx_wr_data  = cx_wr_en ? w_cx_dec : 16'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         cx_q <= 16'd0;
    else if ((state_q == IDLE) && start)  cx_q <= cx;
  end
`else
  logic w_unused_bits;

  // Only 0x60-0x7F reach FETCH, so the upper opcode bits never matter here.
  assign w_unused_bits = ^{cx, opcode_q[7:4]};
  assign w_supported   = (opcode[7:5] == 3'b011);
  assign w_taken       = w_jcc_taken;
  assign cx_wr_en      = 1'b0;
  assign cx_wr_data    = 16'd0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      opcode_q <= 8'd0;
      disp_q   <= 8'd0;
      ip_q     <= 16'd0;
      flags_q  <= 16'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            opcode_q <= opcode;
            ip_q     <= ip;
            flags_q  <= flags;
            state_q  <= w_supported ? FETCH : DONE;
          end
        end
        FETCH: begin
          if (!fifo_empty) begin
            disp_q  <= fifo_rd_data;
            state_q <= EVAL;
          end
        end
        EVAL:     state_q <= w_taken ? REDIRECT : DONE;
        REDIRECT: if (branch_ack) state_q <= DONE;
        DONE:     state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en   = (state_q == FETCH) && !fifo_empty;
  assign branch_valid = (state_q == REDIRECT);
  assign branch_ip    = branch_valid ? w_target : 16'd0;
  assign done         = (state_q == DONE);
  assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_jcc_branch_unit.sv
//------------------------------------------------------------------------------
// Module : tb_jcc_branch_unit
// Brief  : Scoreboard bench for jcc_branch_unit (LOOP tests under JCC_LOOP_EN).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jcc_branch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  opcode = 8'd0;
  logic [15:0] ip = 16'd0;
  logic [15:0] flags = 16'd0;
  logic [15:0] cx = 16'd0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rd_data = 8'd0;
  logic        fifo_rd_en;
  logic        cx_wr_en;
  logic [15:0] cx_wr_data;
  logic        branch_valid;
  logic [15:0] branch_ip;
  logic        branch_ack = 1'b0;
  logic        busy;
  logic        done;

  jcc_branch_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .opcode       (opcode),
    .ip           (ip),
    .flags        (flags),
    .cx           (cx),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .cx_wr_en     (cx_wr_en),
    .cx_wr_data   (cx_wr_data),
    .branch_valid (branch_valid),
    .branch_ip    (branch_ip),
    .branch_ack   (branch_ack),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [15:0] tip;
    int          cxw;
    logic [15:0] cxd;
    int          pops;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int          o_pops = 0;
  int          o_cxw  = 0;
  logic [15:0] o_cxd  = 16'd0;
  logic        o_taken = 1'b0;
  logic [15:0] o_ip   = 16'd0;
  logic        pop_req = 1'b0;

  localparam logic [15:0] F_CF = 16'h0001;
  localparam logic [15:0] F_PF = 16'h0004;
  localparam logic [15:0] F_ZF = 16'h0040;
  localparam logic [15:0] F_SF = 16'h0080;
  localparam logic [15:0] F_OF = 16'h0800;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: gathers DUT activity and scores it against the queue on each done.
  always @(negedge clk) begin
    if (!reset_n) begin
      o_pops = 0; o_cxw = 0; o_cxd = 16'd0; o_taken = 1'b0; o_ip = 16'd0;
    end else begin
      if (fifo_rd_en) begin o_pops++; pop_req = 1'b1; end
      if (cx_wr_en) begin o_cxw++; o_cxd = cx_wr_data; end
      if (branch_valid && branch_ack) begin o_taken = 1'b1; o_ip = branch_ip; end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_taken", {31'd0, o_taken}, {31'd0, e.taken});
          if (e.taken) check("sb_branch_ip", {16'd0, o_ip}, {16'd0, e.tip});
          check("sb_cx_wr_count", o_cxw, e.cxw);
          if (e.cxw != 0) check("sb_cx_wr_data", {16'd0, o_cxd}, {16'd0, e.cxd});
          check("sb_pops", o_pops, e.pops);
        end
        o_pops = 0; o_cxw = 0; o_cxd = 16'd0; o_taken = 1'b0; o_ip = 16'd0;
      end
    end
  end

  // Single-entry FIFO model: a popped byte leaves the head on the next edge.
  always @(posedge clk) begin
    #1;
    if (pop_req) begin fifo_empty = 1'b1; pop_req = 1'b0; end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fifo_load(input logic [7:0] b);
    fifo_rd_data = b;
    fifo_empty   = 1'b0;
  endtask

  task automatic push_exp(input logic t, input logic [15:0] tip, input int cxw,
                          input logic [15:0] cxd, input int pops);
    exp_t e;
    e.taken = t; e.tip = tip; e.cxw = cxw; e.cxd = cxd; e.pops = pops;
    exp_q.push_back(e);
  endtask

  // Leaves the bench in cycle 1 (first cycle after start was sampled);
  // the inputs are scrambled afterwards to prove they were latched.
  task automatic issue(input logic [7:0] op, input logic [15:0] ipv,
                       input logic [15:0] fl, input logic [15:0] cxv);
    tick();
    start = 1'b1; opcode = op; ip = ipv; flags = fl; cx = cxv;
    tick();
    start = 1'b0; opcode = 8'h00; ip = ~ipv; flags = ~fl; cx = ~cxv;
  endtask

  task automatic finish_branch();
    bit ended = 1'b0;
    for (int i = 0; i < 30 && !ended; i++) begin
      @(negedge clk);
      if (branch_valid) begin
        tick(); branch_ack = 1'b1;
        tick(); branch_ack = 1'b0;
        ended = 1'b1;
      end else if (done) begin
        ended = 1'b1;
      end else begin
        tick();
      end
    end
    if (!ended) check("branch_timeout", 32'd1, 32'd0);
    ended = 1'b0;
    for (int i = 0; i < 10 && !ended; i++) begin
      @(negedge clk);
      if (!busy) ended = 1'b1;
    end
    if (!ended) check("idle_timeout", 32'd1, 32'd0);
    fifo_empty = 1'b1;
  endtask

  task automatic run(input logic [7:0] op, input logic [15:0] ipv, input logic [15:0] fl,
                     input logic [15:0] cxv, input logic [7:0] disp, input logic t,
                     input logic [15:0] tip, input int cxw, input logic [15:0] cxd,
                     input int pops);
    push_exp(t, tip, cxw, cxd, pops);
    fifo_load(disp);
    issue(op, ipv, fl, cxv);
    finish_branch();
  endtask

  initial begin
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_branch_valid", {31'd0, branch_valid}, 32'd0);
    check("rst_branch_ip", {16'd0, branch_ip}, 32'd0);
    check("rst_cx_wr", {15'd0, cx_wr_en, cx_wr_data}, 32'd0);
    check("rst_fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;

    // JE taken: cycle-accurate latency
    push_exp(1'b1, 16'h1010, 0, 16'h0000, 1);
    fifo_load(8'h10);
    issue(8'h74, 16'h1000, F_ZF, 16'h0000);
    @(negedge clk);
    check("je_pop_c1", {31'd0, fifo_rd_en}, 32'd1);
    check("je_busy_c1", {31'd0, busy}, 32'd1);
    tick(); @(negedge clk);
    check("je_valid_c2", {31'd0, branch_valid}, 32'd0);
    tick(); @(negedge clk);
    check("je_valid_c3", {31'd0, branch_valid}, 32'd1);
    check("je_ip_c3", {16'd0, branch_ip}, 32'h1010);
    tick(); @(negedge clk);
    check("je_valid_c4", {31'd0, branch_valid}, 32'd1);
    tick(); branch_ack = 1'b1; @(negedge clk);
    check("je_done_c5", {31'd0, done}, 32'd0);
    tick(); branch_ack = 1'b0; @(negedge clk);
    check("je_done_c6", {31'd0, done}, 32'd1);
    check("je_valid_c6", {31'd0, branch_valid}, 32'd0);
    tick(); @(negedge clk);
    check("je_busy_c7", {31'd0, busy}, 32'd0);

    // JNE not taken, FIFO empty for 4 cycles
    push_exp(1'b0, 16'h0000, 0, 16'h0000, 1);
    issue(8'h75, 16'h2000, F_ZF, 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("jne_no_pop_while_empty", {31'd0, fifo_rd_en}, 32'd0);
      tick();
    end
    fifo_load(8'hF0);
    @(negedge clk);
    check("jne_pop", {31'd0, fifo_rd_en}, 32'd1);
    tick(); @(negedge clk);
    check("jne_eval_no_done", {31'd0, done}, 32'd0);
    tick(); @(negedge clk);
    check("jne_done_pop_plus2", {31'd0, done}, 32'd1);
    check("jne_no_valid", {31'd0, branch_valid}, 32'd0);
    tick();

    // Target arithmetic and condition coverage
    run(8'h7C, 16'h0002, F_SF, 16'h0, 8'hFC, 1'b1, 16'hFFFE, 0, 16'h0, 1);
    run(8'h70, 16'h7FFF, F_OF, 16'h0, 8'h01, 1'b1, 16'h8000, 0, 16'h0, 1);
    run(8'h62, 16'h0000, F_CF, 16'h0, 8'hFF, 1'b1, 16'hFFFF, 0, 16'h0, 1);
    run(8'h7F, 16'h6000, F_ZF, 16'h0, 8'h20, 1'b0, 16'h0000, 0, 16'h0, 1);
    run(8'h7A, 16'h6100, F_PF, 16'h0, 8'h7F, 1'b1, 16'h617F, 0, 16'h0, 1);
    run(8'h6E, 16'h6200, F_SF, 16'h0, 8'h00, 1'b1, 16'h6200, 0, 16'h0, 1);
    run(8'h73, 16'h6300, F_CF, 16'h0, 8'h40, 1'b0, 16'h0000, 0, 16'h0, 1);

`ifdef JCC_LOOP_EN
    run(8'hE2, 16'h3000, 16'h0, 16'h0001, 8'h05, 1'b0, 16'h0000, 1, 16'h0000, 1);
    run(8'hE2, 16'h3000, 16'h0, 16'h0000, 8'h05, 1'b1, 16'h3005, 1, 16'hFFFF, 1);
    run(8'hE3, 16'h3100, 16'h0, 16'h0000, 8'h80, 1'b1, 16'h3080, 0, 16'h0000, 1);
    run(8'hE3, 16'h3100, 16'h0, 16'h0002, 8'h80, 1'b0, 16'h0000, 0, 16'h0000, 1);
    run(8'hE1, 16'h3200, 16'h0, 16'h0005, 8'h10, 1'b0, 16'h0000, 1, 16'h0004, 1);
    run(8'hE0, 16'h3200, 16'h0, 16'h0005, 8'h10, 1'b1, 16'h3210, 1, 16'h0004, 1);
`else
    run(8'hE2, 16'h3000, 16'h0, 16'h0001, 8'h05, 1'b0, 16'h0000, 0, 16'h0000, 0);
    run(8'hE3, 16'h3100, 16'h0, 16'h0000, 8'h80, 1'b0, 16'h0000, 0, 16'h0000, 0);
`endif

    // Start during FETCH is ignored
    push_exp(1'b1, 16'h4008, 0, 16'h0000, 1);
    issue(8'h75, 16'h4000, 16'h0000, 16'h0000);
    tick();
    start = 1'b1; opcode = 8'h70; ip = 16'h9000; flags = F_OF;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("busy_start_ignored_fetch", {30'd0, busy, fifo_rd_en}, 32'd2);
    fifo_load(8'h08);
    finish_branch();
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    check("busy_after_ignored", {31'd0, busy}, 32'd0);

    // Unsupported opcode
    push_exp(1'b0, 16'h0000, 0, 16'h0000, 0);
    fifo_load(8'hAA);
    issue(8'h90, 16'h5000, 16'h0000, 16'h0000);
    @(negedge clk);
    check("unsup_done_c1", {31'd0, done}, 32'd1);
    check("unsup_no_pop", {31'd0, fifo_rd_en}, 32'd0);
    tick(); @(negedge clk);
    check("unsup_idle_c2", {31'd0, busy}, 32'd0);
    fifo_empty = 1'b1;

    // Abort in REDIRECT
    push_exp(1'b1, 16'h5010, 0, 16'h0000, 1);
    fifo_load(8'h10);
    issue(8'h74, 16'h5000, F_ZF, 16'h0000);
    tick(); tick(); @(negedge clk);
    check("abort_in_redirect", {31'd0, branch_valid}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, branch_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    tick(); tick();
    reset_n = 1'b1;
    run(8'h74, 16'h5100, F_ZF, 16'h0, 8'h20, 1'b1, 16'h5120, 0, 16'h0, 1);

    for (int i = 0; i < 3; i++) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
